// File: rtl/jericalla_pipe_param.sv
`default_nettype none
// ============================================================================
//  Module   : jericalla_pipe_param
//  Brief    : Parametrised 3-stage (Issue / X / M) ALU + data-memory pipeline
//             with operand forwarding and a one-cycle load-use stall.
//  Revision : 1.0  initial release
// ============================================================================
module jericalla_pipe_param #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 6
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        INSTR_VALID,
    input  logic [3+3*REG_ADDR_W-1:0]   INSTR,
    output logic                        INSTR_READY,
    output logic                        OUT_VALID,
    output logic [DATA_W-1:0]           OUT_DATA
);

    localparam int c_INSTR_W = 3 + 3 * REG_ADDR_W;
    localparam int c_NREGS   = 1 << REG_ADDR_W;
    localparam int c_DEPTH   = 1 << MEM_ADDR_W;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_SLT = 3'd2;
    localparam logic [2:0] c_OP_AND = 3'd3;
    localparam logic [2:0] c_OP_OR  = 3'd4;
    localparam logic [2:0] c_OP_LI  = 3'd5;
    localparam logic [2:0] c_OP_SW  = 3'd6;
    localparam logic [2:0] c_OP_LW  = 3'd7;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      r_rf  [c_NREGS];
    logic [DATA_W-1:0]      r_mem [c_DEPTH];

    // X stage
    logic                   r_x_valid;
    logic [2:0]             r_x_op;
    logic [REG_ADDR_W-1:0]  r_x_wa;
    logic [DATA_W-1:0]      r_x_a;
    logic [DATA_W-1:0]      r_x_b;

    // M stage
    logic                   r_m_valid;
    logic [2:0]             r_m_op;
    logic [REG_ADDR_W-1:0]  r_m_wa;
    logic [DATA_W-1:0]      r_m_res;
    logic [MEM_ADDR_W-1:0]  r_m_addr;

    // Retire port
    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_out_data;

    // ------------------------------------------------------------------
    // Issue-stage decode
    // ------------------------------------------------------------------
    logic [2:0]             w_op;
    logic [REG_ADDR_W-1:0]  w_wa;
    logic [REG_ADDR_W-1:0]  w_ra1;
    logic [REG_ADDR_W-1:0]  w_ra2;
    logic                   w_use1;
    logic                   w_use2;
    logic [DATA_W-1:0]      w_imm;

    assign w_op   = INSTR[c_INSTR_W-1 -: 3];
    assign w_wa   = INSTR[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_ra1  = INSTR[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign w_ra2  = INSTR[REG_ADDR_W-1:0];
    assign w_use1 = (w_op != c_OP_LI);
    assign w_use2 = (w_op != c_OP_LI) && (w_op != c_OP_LW);
    assign w_imm  = DATA_W'({w_ra1, w_ra2});

    // ------------------------------------------------------------------
    // X-stage ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      w_x_result;
    logic                   w_x_fwd_ok;

    always_comb begin
        w_x_result = '0;
        case (r_x_op)
            c_OP_ADD: w_x_result = r_x_a + r_x_b;
            c_OP_SUB: w_x_result = r_x_a - r_x_b;
            c_OP_SLT: w_x_result[0] = ($signed(r_x_a) < $signed(r_x_b));
            c_OP_AND: w_x_result = r_x_a & r_x_b;
            c_OP_OR:  w_x_result = r_x_a | r_x_b;
            c_OP_LI:  w_x_result = r_x_a;
            c_OP_SW:  w_x_result = r_x_b;
            c_OP_LW:  w_x_result = r_x_a;
            default:  w_x_result = '0;
        endcase
    end

    // A load's value is not known until M, so X never forwards for LW.
    assign w_x_fwd_ok = r_x_valid && (r_x_op != c_OP_SW) && (r_x_op != c_OP_LW)
                        && (r_x_wa != '0);

    // ------------------------------------------------------------------
    // M-stage memory read and write-data select
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      w_m_rdata;
    logic [DATA_W-1:0]      w_m_wdata;
    logic                   w_m_fwd_ok;
    logic                   w_m_rf_we;

    assign w_m_rdata  = r_mem[r_m_addr];
    assign w_m_wdata  = (r_m_op == c_OP_LW) ? w_m_rdata : r_m_res;
    assign w_m_fwd_ok = r_m_valid && (r_m_op != c_OP_SW) && (r_m_wa != '0);
    assign w_m_rf_we  = w_m_fwd_ok;

    // ------------------------------------------------------------------
    // Source operand resolution: X first, then M, then register file
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_src
        logic [REG_ADDR_W-1:0]  w_idx;
        logic [DATA_W-1:0]      w_val;

        assign w_idx = (g == 0) ? w_ra1 : w_ra2;

        always_comb begin
            w_val = '0;
            if (w_idx == '0)
                w_val = '0;
            else if (w_x_fwd_ok && (r_x_wa == w_idx))
                w_val = w_x_result;
            else if (w_m_fwd_ok && (r_m_wa == w_idx))
                w_val = w_m_wdata;
            else
                w_val = r_rf[w_idx];
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard and handshake
    // ------------------------------------------------------------------
    logic                   w_stall;
    logic                   w_accept;
    logic [DATA_W-1:0]      w_iss_a;
    logic [DATA_W-1:0]      w_iss_b;

    assign w_stall = INSTR_VALID && r_x_valid && (r_x_op == c_OP_LW) && (r_x_wa != '0)
                     && ((w_use1 && (w_ra1 == r_x_wa)) || (w_use2 && (w_ra2 == r_x_wa)));

    assign INSTR_READY = RST_N && !w_stall;
    assign w_accept    = INSTR_VALID && INSTR_READY;

    // LI carries its immediate through the A operand slot.
    assign w_iss_a = (w_op == c_OP_LI) ? w_imm : g_src[0].w_val;
    assign w_iss_b = g_src[1].w_val;

    // ------------------------------------------------------------------
    // X-stage register (a stall or idle cycle inserts a bubble)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_x_valid <= 1'b0;
            r_x_op    <= '0;
            r_x_wa    <= '0;
            r_x_a     <= '0;
            r_x_b     <= '0;
        end else begin
            r_x_valid <= w_accept;
            if (w_accept) begin
                r_x_op <= w_op;
                r_x_wa <= w_wa;
                r_x_a  <= w_iss_a;
                r_x_b  <= w_iss_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // M-stage register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_m_valid <= 1'b0;
            r_m_op    <= '0;
            r_m_wa    <= '0;
            r_m_res   <= '0;
            r_m_addr  <= '0;
        end else begin
            r_m_valid <= r_x_valid;
            if (r_x_valid) begin
                r_m_op   <= r_x_op;
                r_m_wa   <= r_x_wa;
                r_m_res  <= w_x_result;
                r_m_addr <= r_x_a[MEM_ADDR_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file write-back
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < c_NREGS; i++)
                r_rf[i] <= '0;
        end else if (w_m_rf_we) begin
            r_rf[r_m_wa] <= w_m_wdata;
        end
    end

    // Data memory keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (r_m_valid && (r_m_op == c_OP_SW))
            r_mem[r_m_addr] <= r_m_res;
    end

    // ------------------------------------------------------------------
    // Retire port
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_m_valid;
            if (r_m_valid)
                r_out_data <= w_m_wdata;
        end
    end

    assign OUT_VALID = r_out_valid;
    assign OUT_DATA  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_jericalla_pipe_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jericalla_pipe_param
//  Brief    : Scoreboard bench for jericalla_pipe_param (sequential ISA model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_jericalla_pipe_param;

    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int MAW = 6;
    localparam int IW  = 3 + 3 * RAW;

    localparam logic [2:0] c_ADD = 3'd0;
    localparam logic [2:0] c_SUB = 3'd1;
    localparam logic [2:0] c_SLT = 3'd2;
    localparam logic [2:0] c_LI  = 3'd5;
    localparam logic [2:0] c_SW  = 3'd6;
    localparam logic [2:0] c_LW  = 3'd7;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           INSTR_VALID;
    logic [IW-1:0]  INSTR;
    logic           INSTR_READY;
    logic           OUT_VALID;
    logic [DW-1:0]  OUT_DATA;

    jericalla_pipe_param #(
        .DATA_W     (DW),
        .REG_ADDR_W (RAW),
        .MEM_ADDR_W (MAW)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .INSTR_VALID (INSTR_VALID),
        .INSTR       (INSTR),
        .INSTR_READY (INSTR_READY),
        .OUT_VALID   (OUT_VALID),
        .OUT_DATA    (OUT_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } sb_t;

    sb_t            sb[$];
    sb_t            mon_e;
    int             n_checks  = 0;
    int             n_errors  = 0;
    int             cyc       = 0;
    int             n_retired = 0;
    int             base;
    logic [DW-1:0]  m_rf  [1 << RAW];
    logic [DW-1:0]  m_mem [1 << MAW];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int idx);
        return (idx == 0) ? '0 : m_rf[idx];
    endfunction

    // Drive one instruction, wait for acceptance, model it, queue the retire.
    task automatic issue(input logic [2:0] op, input int wa, input int ra1, input int ra2,
                         input int exp_stall, input string tag);
        logic [DW-1:0] a, b, res;
        int stalls;
        INSTR_VALID = 1'b1;
        INSTR       = {op, wa[RAW-1:0], ra1[RAW-1:0], ra2[RAW-1:0]};
        stalls      = 0;
        #1;
        while (!INSTR_READY && stalls < 4) begin
            stalls++;
            @(negedge CLK);
            #1;
        end
        check_val({tag, "_stalls"}, stalls, exp_stall);
        if (!INSTR_READY) begin
            check_val({tag, "_accept"}, 0, 1);
            INSTR_VALID = 1'b0;
            @(negedge CLK);
            return;
        end
        a   = rd(ra1);
        b   = rd(ra2);
        res = '0;
        case (op)
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: res = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd3: res = a & b;
            3'd4: res = a | b;
            3'd5: res = (ra1 << RAW) + ra2;
            3'd6: begin m_mem[a[MAW-1:0]] = b; res = b; end
            default: res = m_mem[a[MAW-1:0]];
        endcase
        if (op != c_SW && wa != 0)
            m_rf[wa] = res;
        sb.push_back('{res, cyc + 3});
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        INSTR_VALID = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    // Retire monitor: every pulse must match the oldest expected entry and cycle.
    always @(negedge CLK) begin
        if (OUT_VALID === 1'b1) begin
            n_retired++;
            if (sb.size() == 0) begin
                check_val("unexpected_retire", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_val("ret_data", OUT_DATA, mon_e.data);
                check_val("ret_cycle", cyc, mon_e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_val("missing_retire", 0, 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << RAW); i++) m_rf[i] = '0;
        RST_N       = 1'b0;
        INSTR_VALID = 1'b0;
        INSTR       = '0;
        repeat (3) @(negedge CLK);
        check_val("rst_ready", INSTR_READY, 0);
        check_val("rst_out_valid", OUT_VALID, 0);
        check_val("rst_out_data", OUT_DATA, 0);
        RST_N = 1'b1;
        #1;
        check_val("idle_ready", INSTR_READY, 1);
        @(negedge CLK);
        check_val("idle_out_valid", OUT_VALID, 0);
        check_val("idle_out_data", OUT_DATA, 0);

        // Back-to-back forwarding
        issue(c_LI,  1, 0, 5, 0, "li_r1");
        issue(c_LI,  2, 0, 3, 0, "li_r2");
        issue(c_ADD, 3, 1, 2, 0, "add_r3");
        // SUB and signed SLT
        issue(c_SUB, 4, 2, 1, 0, "sub_r4");
        issue(c_SLT, 5, 4, 1, 0, "slt_r5");
        issue(c_SLT, 6, 1, 4, 0, "slt_r6");
        // Store / load / load-use stall
        issue(c_SW,  0, 1, 3, 0, "sw_r1");
        issue(c_LW,  7, 1, 0, 0, "lw_r7");
        issue(c_ADD, 8, 7, 7, 1, "add_r8");
        // r0 and address wrap
        issue(c_LI,  0, 0, 7, 0, "li_r0");
        issue(c_ADD, 9, 0, 0, 0, "add_r9");
        issue(c_LI, 10, 2, 2, 0, "li_r10");
        issue(c_SW,  0, 10, 3, 0, "sw_r10");
        issue(c_LI, 11, 0, 2, 0, "li_r11");
        issue(c_LW, 12, 11, 0, 0, "lw_r12");
        idle(4);
        check_val("hold_out_valid", OUT_VALID, 0);
        check_val("hold_out_data", OUT_DATA, 32'd8);

        // Reset with two instructions in flight
        base = n_retired;
        issue(c_LI, 13, 0, 9, 0, "li_r13");
        issue(c_LI, 14, 0, 4, 0, "li_r14");
        INSTR_VALID = 1'b0;
        RST_N       = 1'b0;
        #1;
        sb.delete();
        for (int i = 0; i < (1 << RAW); i++) m_rf[i] = '0;
        check_val("midrst_out_valid", OUT_VALID, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check_val("midrst_dropped", n_retired - base, 0);
        issue(c_ADD, 15, 13, 14, 0, "add_r15");
        idle(4);
        check_val("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
